nes_controller_reader: RTL and testbench

NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

---
 rtl/nes_pkg.sv | 27 ++
 rtl/nes_input_sync.sv | 28 ++
 rtl/nes_controller_reader.sv | 174 +++++++++++++++++
 tb/tb_nes_controller_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// nes_pkg
// Shared definitions for the NES controller reader: FSM state encoding,
// button bit positions within btn_p1/btn_p2, and the serial frame length.
// No ports (package).
package nes_pkg;

  localparam int NES_BITS = 8;

  // Bit positions in the decoded button byte (shift order from the pad)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } nes_state_t;

endpackage

// File: rtl/nes_input_sync.sv
// nes_input_sync
// Two-flop synchronizer for one controller data line. Flops reset to 1,
// the idle/unplugged level of the active-low data line.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   d       - asynchronous input
//   q       - synchronized output
module nes_input_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_controller_reader.sv
// nes_controller_reader
// Reads two NES controllers in parallel on each poll strobe. Drives one
// latch pulse, then eight shift-clock periods, sampling both serial data
// lines at the end of each clock-low phase. Decoded buttons (active-high)
// are published together with a one-cycle btn_valid pulse.
//
// Build option: define NES_INPUT_SYNC_EN to pass both data inputs through
// 2-flop synchronizers (nes_input_sync). Default build samples directly.
//
// State table:
//   state | meaning
//   IDLE  | waiting for poll; latch low, shift clock high
//   LATCH | latch high for 2*HALF_PERIOD cycles
//   LOW   | shift clock low for HALF_PERIOD cycles; sample on last cycle
//   HIGH  | shift clock high for HALF_PERIOD cycles; pad shifts next bit
//   DONE  | one cycle; buttons updated, btn_valid high
//
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   poll         - single-cycle read request (ignored while busy)
//   nes_data_p1  - controller 1 serial data, active-low
//   nes_data_p2  - controller 2 serial data, active-low
//   nes_latch    - latch to both controllers, active-high
//   nes_clk      - shift clock to both controllers, idle high
//   btn_p1       - controller 1 buttons, active-high
//   btn_p2       - controller 2 buttons, active-high
//   btn_valid    - one-cycle pulse when btn_p1/btn_p2 update
//   busy         - high while a read is in progress
module nes_controller_reader
  import nes_pkg::*;
#(
  parameter int HALF_PERIOD = 151
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                poll,
  input  logic                nes_data_p1,
  input  logic                nes_data_p2,
  output logic                nes_latch,
  output logic                nes_clk,
  output logic [NES_BITS-1:0] btn_p1,
  output logic [NES_BITS-1:0] btn_p2,
  output logic                btn_valid,
  output logic                busy
);

  // Counter spans the longest phase (LATCH, 2*HALF_PERIOD cycles)
  localparam int CW = $clog2(HALF_PERIOD * 2);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [2:0]    BIT_LAST   = 3'(NES_BITS - 1);

  nes_state_t          state;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [NES_BITS-1:0] sr_p1;
  logic [NES_BITS-1:0] sr_p2;
  logic                data_p1;
  logic                data_p2;

`ifdef NES_INPUT_SYNC_EN
  nes_input_sync u_sync_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (nes_data_p1),
    .q       (data_p1)
  );

  nes_input_sync u_sync_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (nes_data_p2),
    .q       (data_p2)
  );
`else
  assign data_p1 = nes_data_p1;
  assign data_p2 = nes_data_p2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sr_p1     <= '0;
      sr_p2     <= '0;
      btn_p1    <= '0;
      btn_p2    <= '0;
      btn_valid <= 1'b0;
      busy      <= 1'b0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b1;
    end else begin
      btn_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          nes_latch <= 1'b0;
          nes_clk   <= 1'b1;
          busy      <= 1'b0;
          if (poll) begin
            state     <= ST_LATCH;
            cnt       <= '0;
            bit_idx   <= '0;
            sr_p1     <= '0;
            sr_p2     <= '0;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_LATCH: begin
          if (cnt == LATCH_LAST) begin
            state     <= ST_LOW;
            cnt       <= '0;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_LOW: begin
          if (cnt == HALF_LAST) begin
            // Data lines are active-low; store pressed as 1
            sr_p1[bit_idx] <= ~data_p1;
            sr_p2[bit_idx] <= ~data_p2;
            state          <= ST_HIGH;
            cnt            <= '0;
            nes_clk        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              // Publish on entry so outputs and btn_valid align with DONE
              state     <= ST_DONE;
              btn_p1    <= sr_p1;
              btn_p2    <= sr_p2;
              btn_valid <= 1'b1;
            end else begin
              state   <= ST_LOW;
              bit_idx <= bit_idx + 1'b1;
              nes_clk <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          bit_idx <= '0;
          busy    <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          bit_idx   <= '0;
          busy      <= 1'b0;
          nes_latch <= 1'b0;
          nes_clk   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;

  localparam int HP  = 4;
  localparam int HPS = 151;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       poll = 1'b0;
  logic       poll_s = 1'b0;

  logic       d_p1, d_p2, latch_f, nclk_f, valid_f, busy_f;
  logic [7:0] btn1_f, btn2_f;
  logic       ds_p1, ds_p2, latch_s, nclk_s, valid_s, busy_s;
  logic [7:0] btn1_s, btn2_s;

  // Controller models: pressed buttons (active-high) and plugged flags
  logic [7:0] press1 = 8'h00, press2 = 8'h00;
  logic       plug1 = 1'b1, plug2 = 1'b1;
  logic [7:0] sr_f1, sr_f2, sr_s1, sr_s2;
  logic       nclk_f_d, nclk_s_d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nes_controller_reader #(.HALF_PERIOD(HP)) u_dut (
    .clk(clk), .reset_n(reset_n), .poll(poll),
    .nes_data_p1(d_p1), .nes_data_p2(d_p2),
    .nes_latch(latch_f), .nes_clk(nclk_f),
    .btn_p1(btn1_f), .btn_p2(btn2_f),
    .btn_valid(valid_f), .busy(busy_f)
  );

  nes_controller_reader #(.HALF_PERIOD(HPS)) u_dut_slow (
    .clk(clk), .reset_n(reset_n), .poll(poll_s),
    .nes_data_p1(ds_p1), .nes_data_p2(ds_p2),
    .nes_latch(latch_s), .nes_clk(nclk_s),
    .btn_p1(btn1_s), .btn_p2(btn2_s),
    .btn_valid(valid_s), .busy(busy_s)
  );

  // 4021-style pad: parallel load while latched, shift on nes_clk rise
  always @(posedge clk) begin
    nclk_f_d <= nclk_f;
    if (latch_f) begin
      sr_f1 <= ~press1;
      sr_f2 <= ~press2;
    end else if (nclk_f && !nclk_f_d) begin
      sr_f1 <= {1'b1, sr_f1[7:1]};
      sr_f2 <= {1'b1, sr_f2[7:1]};
    end
  end

  always @(posedge clk) begin
    nclk_s_d <= nclk_s;
    if (latch_s) begin
      sr_s1 <= ~press1;
      sr_s2 <= ~press2;
    end else if (nclk_s && !nclk_s_d) begin
      sr_s1 <= {1'b1, sr_s1[7:1]};
      sr_s2 <= {1'b1, sr_s2[7:1]};
    end
  end

  assign d_p1  = plug1 ? sr_f1[0] : 1'b1;
  assign d_p2  = plug2 ? sr_f2[0] : 1'b1;
  assign ds_p1 = plug1 ? sr_s1[0] : 1'b1;
  assign ds_p2 = plug2 ? sr_s2[0] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read on the fast DUT. j counts negedges after the poll-sampling edge.
  task automatic do_read(input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] h1, input logic [7:0] h2,
                         input int dup_at, input bit wave);
    int vcount;
    int vj;
    logic el, ec;
    vcount = 0;
    vj = -1;
    @(negedge clk) poll = 1'b1;
    @(posedge clk);
    #1 poll = 1'b0;
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      poll = (j == dup_at);
      if (valid_f) begin
        vcount++;
        if (vj < 0) vj = j;
      end
      if (wave && j <= 74) begin
        if (j < 2*HP) begin
          el = 1'b1; ec = 1'b1;
        end else if (j < 18*HP) begin
          el = 1'b0; ec = (((j - 2*HP) / HP) % 2) == 1;
        end else begin
          el = 1'b0; ec = 1'b1;
        end
        chk($sformatf("latch_j%0d", j), latch_f, el);
        chk($sformatf("nclk_j%0d", j), nclk_f, ec);
      end
      if (dup_at >= 0 && j <= 18*HP) chk($sformatf("busy_j%0d", j), busy_f, 1'b1);
      if (j == 40) begin
        chk("hold_p1", btn1_f, h1);
        chk("hold_p2", btn2_f, h2);
        chk("busy_mid", busy_f, 1'b1);
      end
    end
    poll = 1'b0;
    chk("valid_count", vcount, 1);
    chk("valid_latency", vj, 18*HP);
    chk("btn_p1", btn1_f, e1);
    chk("btn_p2", btn2_f, e2);
    chk("busy_after", busy_f, 1'b0);
  endtask

  initial begin
    int vcount;
    int vj;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_latch", latch_f, 1'b0);
    chk("rst_nclk", nclk_f, 1'b1);
    chk("rst_p1", btn1_f, 8'h00);
    chk("rst_p2", btn2_f, 8'h00);
    chk("rst_valid", valid_f, 1'b0);
    chk("rst_busy", busy_f, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // A+Start on pad 1, nothing on pad 2, full waveform check
    press1 = 8'h09; press2 = 8'h00;
    do_read(8'h09, 8'h00, 8'h00, 8'h00, -1, 1'b1);

    // Second poll 10 cycles into the read is ignored
    press1 = 8'h80; press2 = 8'h12;
    do_read(8'h80, 8'h12, 8'h09, 8'h00, 10, 1'b0);

    // Reset 30 cycles into a read aborts it
    press1 = 8'hFF; press2 = 8'hFF;
    @(negedge clk) poll = 1'b1;
    @(posedge clk);
    #1 poll = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_latch", latch_f, 1'b0);
    chk("abort_nclk", nclk_f, 1'b1);
    chk("abort_p1", btn1_f, 8'h00);
    chk("abort_p2", btn2_f, 8'h00);
    chk("abort_busy", busy_f, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    vcount = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (valid_f) vcount++;
    end
    chk("abort_no_valid", vcount, 0);
    chk("abort_idle_busy", busy_f, 1'b0);

    // All pressed, then unplugged
    do_read(8'hFF, 8'hFF, 8'h00, 8'h00, -1, 1'b0);
    plug1 = 1'b0; plug2 = 1'b0;
    do_read(8'h00, 8'h00, 8'hFF, 8'hFF, -1, 1'b0);
    plug1 = 1'b1; plug2 = 1'b1;

    // Full-rate instance: 18*151 cycle latency
    press1 = 8'h09; press2 = 8'hA5;
    @(negedge clk) poll_s = 1'b1;
    @(posedge clk);
    #1 poll_s = 1'b0;
    vcount = 0;
    vj = -1;
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      if (valid_s) begin
        vcount++;
        if (vj < 0) vj = j;
      end
    end
    chk("slow_valid_count", vcount, 1);
    chk("slow_latency", vj, 18*HPS);
    chk("slow_p1", btn1_s, 8'h09);
    chk("slow_p2", btn2_s, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
